instr_fetch_unit: RTL and testbench

Fetch stage directly upstream of the control unit. Holds the program counter, fetches 16-bit instructions from instruction memory over a ready handshake, and latches each instruction into an instruction register. Presents the decoded fields, including the 3-bit opcode, to the control unit and the register file. Accepts jump redirects from downstream.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/instr_fetch_unit_if.sv | 34 +++
 rtl/if_perf_counter.sv | 19 +
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 tb/tb_instr_fetch_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions and the fetch state encoding.
// Imported by the fetch unit and the control unit.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 3;
    localparam int unsigned REG_W    = 3;
    localparam int unsigned IMM_W    = 7;
    localparam int unsigned CNT_W    = 16;

    localparam int unsigned OPCODE_MSB = 15;
    localparam int unsigned OPCODE_LSB = 13;
    localparam int unsigned RS_MSB     = 12;
    localparam int unsigned RS_LSB     = 10;
    localparam int unsigned RT_MSB     = 9;
    localparam int unsigned RT_LSB     = 7;
    localparam int unsigned RD_MSB     = 6;
    localparam int unsigned RD_LSB     = 4;
    localparam int unsigned IMM_MSB    = 6;
    localparam int unsigned IMM_LSB    = 0;

    localparam logic [OPCODE_W-1:0] LOAD_WORD     = 3'b001;
    localparam logic [OPCODE_W-1:0] STORE_WORD    = 3'b010;
    localparam logic [OPCODE_W-1:0] JUMP          = 3'b011;
    localparam logic [OPCODE_W-1:0] ADD           = 3'b100;
    localparam logic [OPCODE_W-1:0] ADD_IMMEDIATE = 3'b101;
    localparam logic [OPCODE_W-1:0] SUBTRACT      = 3'b110;

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_FULL = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake, decode handshake, redirect and decoded fields.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 16
);
    import cpu_pkg::*;

    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_ready;
    logic [INSTR_W-1:0]  imem_rdata;
    logic                id_ready;
    logic                jump_en;
    logic [ADDR_W-1:0]   jump_target;
    logic                if_valid;
    logic [INSTR_W-1:0]  instr;
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [IMM_W-1:0]    imm;
    logic [ADDR_W-1:0]   pc_out;

    modport master (
        output imem_req, imem_addr, if_valid, instr, opcode, rs, rt, rd, imm, pc_out,
        input  imem_ready, imem_rdata, id_ready, jump_en, jump_target
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, instr, opcode, rs, rt, rd, imm, pc_out,
        output imem_ready, imem_rdata, id_ready, jump_en, jump_target
    );

endinterface

// File: rtl/if_perf_counter.sv
// Saturating event counter used for the optional fetch performance counters.
module if_perf_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, instruction-memory request/response handshake and instruction register.
// Optional macro IF_PERF_COUNT_EN adds fetch_count/stall_count saturating counters.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned PC_RESET = 0,
    parameter int unsigned PC_STEP  = 1
) (
    input  logic               clk,
    input  logic               reset,
`ifdef IF_PERF_COUNT_EN
    output logic [CNT_W-1:0]   fetch_count,
    output logic [CNT_W-1:0]   stall_count,
`endif
    instr_fetch_unit_if.master bus
);

    fetch_state_t       state, state_nx;
    logic [ADDR_W-1:0]  pc, pc_nx;
    logic [ADDR_W-1:0]  pc_out_q, pc_out_nx;
    logic [INSTR_W-1:0] instr_q, instr_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_REQ;
            pc       <= ADDR_W'(PC_RESET);
            pc_out_q <= '0;
            instr_q  <= '0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            pc_out_q <= pc_out_nx;
            instr_q  <= instr_nx;
        end
    end

    // A redirect always wins: it drops any returning data and any held instruction.
    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        pc_out_nx = pc_out_q;
        instr_nx  = instr_q;
        case (state)
            S_REQ: begin
                if (bus.jump_en) begin
                    pc_nx = bus.jump_target;
                end else if (bus.imem_ready) begin
                    instr_nx  = bus.imem_rdata;
                    pc_out_nx = pc;
                    pc_nx     = pc + ADDR_W'(PC_STEP);
                    state_nx  = S_FULL;
                end
            end
            S_FULL: begin
                if (bus.jump_en) begin
                    pc_nx    = bus.jump_target;
                    state_nx = S_REQ;
                end else if (bus.id_ready) begin
                    state_nx = S_REQ;
                end
            end
        endcase
    end

    // Request is a state decode, forced low while reset is held.
    assign bus.imem_req  = (state == S_REQ) && !reset;
    assign bus.imem_addr = pc;
    assign bus.if_valid  = (state == S_FULL);
    assign bus.instr     = instr_q;
    assign bus.pc_out    = pc_out_q;
    assign bus.opcode    = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign bus.rs        = instr_q[RS_MSB:RS_LSB];
    assign bus.rt        = instr_q[RT_MSB:RT_LSB];
    assign bus.rd        = instr_q[RD_MSB:RD_LSB];
    assign bus.imm       = instr_q[IMM_MSB:IMM_LSB];

`ifdef IF_PERF_COUNT_EN
    logic fetch_inc_c;
    logic stall_inc_c;

    assign fetch_inc_c = (state == S_REQ) && bus.imem_ready && !bus.jump_en;
    assign stall_inc_c = (state == S_FULL) && !bus.id_ready;

    if_perf_counter #(.WIDTH(CNT_W)) u_fetch_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (fetch_inc_c),
        .count (fetch_count)
    );

    if_perf_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc_c),
        .count (stall_count)
    );
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: behavioural fetch model plus a scoreboard of
// expected (pc, instruction) pairs pushed on each accepted response and popped on delivery.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] ins;
    } exp_t;

    logic clk;
    logic reset;
`ifdef IF_PERF_COUNT_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    instr_fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .PC_RESET(0), .PC_STEP(1)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef IF_PERF_COUNT_EN
        .fetch_count (fetch_count),
        .stall_count (stall_count),
`endif
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [256];
    exp_t        sb [$];
    logic [7:0]  m_pc;
    logic        m_full;
    logic        m_new;
    int          n_pass;
    int          n_total;

    // Drive one cycle of inputs, advance the reference model, then wait to the next falling edge.
    task automatic drive(input logic rdy, input logic idr, input logic jmp, input logic [7:0] tgt);
        exp_t e;
        bus.imem_ready  = rdy;
        bus.id_ready    = idr;
        bus.jump_en     = jmp;
        bus.jump_target = tgt;
        bus.imem_rdata  = mem[m_pc];
        m_new = 1'b0;
        if (!m_full) begin
            if (jmp) begin
                m_pc = tgt;
            end else if (rdy) begin
                e.pc  = m_pc;
                e.ins = mem[m_pc];
                sb.push_back(e);
                m_pc   = m_pc + 8'd1;
                m_full = 1'b1;
                m_new  = 1'b1;
            end
        end else begin
            if (jmp) begin
                m_pc   = tgt;
                m_full = 1'b0;
            end else if (idr) begin
                m_full = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.imem_ready = 1'b0; bus.id_ready = 1'b0; bus.jump_en = 1'b0;
        bus.jump_target = 8'h00; bus.imem_rdata = 16'h0000;
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        n_total++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.imem_req); else n_pass++;
        n_total++; if (bus.if_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.if_valid); else n_pass++;
        n_total++; if (bus.instr !== 16'h0000) $display("FAIL reset_instr: got %h want 0000", bus.instr); else n_pass++;
        n_total++; if (bus.pc_out !== 8'h00) $display("FAIL reset_pc_out: got %h want 00", bus.pc_out); else n_pass++;
        n_total++; if (bus.imem_addr !== 8'h00) $display("FAIL reset_addr: got %h want 00", bus.imem_addr); else n_pass++;
        reset = 1'b0;
        m_pc = 8'h00; m_full = 1'b0; sb.delete();
        #1;
        n_total++; if (bus.imem_req !== 1'b1) $display("FAIL post_reset_req: got %b want 1", bus.imem_req); else n_pass++;
    endtask

    task automatic test_stream();
        exp_t e;
        bit   first = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'h00);
            n_total++; if (bus.if_valid !== m_full) $display("FAIL stream_valid[%0d]: got %b want %b", i, bus.if_valid, m_full); else n_pass++;
            n_total++; if (bus.imem_addr !== m_pc) $display("FAIL stream_addr[%0d]: got %h want %h", i, bus.imem_addr, m_pc); else n_pass++;
            n_total++; if (bus.imem_req !== !m_full) $display("FAIL stream_req[%0d]: got %b want %b", i, bus.imem_req, !m_full); else n_pass++;
            if (m_new) begin
                e = sb.pop_front();
                n_total++; if (bus.instr !== e.ins) $display("FAIL stream_instr[%0d]: got %h want %h", i, bus.instr, e.ins); else n_pass++;
                n_total++; if (bus.pc_out !== e.pc) $display("FAIL stream_pc_out[%0d]: got %h want %h", i, bus.pc_out, e.pc); else n_pass++;
                n_total++; if (bus.imm !== e.ins[6:0]) $display("FAIL stream_imm[%0d]: got %h want %h", i, bus.imm, e.ins[6:0]); else n_pass++;
                n_total++; if ({bus.rs, bus.rt, bus.rd} !== e.ins[12:4]) $display("FAIL stream_regs[%0d]: got %h want %h", i, {bus.rs, bus.rt, bus.rd}, e.ins[12:4]); else n_pass++;
                if (first) begin
                    n_total++; if (bus.opcode !== 3'b001) $display("FAIL first_opcode: got %b want 001", bus.opcode); else n_pass++;
                    n_total++; if (bus.pc_out !== 8'h00) $display("FAIL first_pc_out: got %h want 00", bus.pc_out); else n_pass++;
                    first = 1'b0;
                end else begin
                    n_total++; if (bus.opcode !== e.ins[15:13]) $display("FAIL stream_opcode[%0d]: got %b want %b", i, bus.opcode, e.ins[15:13]); else n_pass++;
                end
            end
        end
        drive(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_stall();
        exp_t e;
        test_reset();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00);
            n_total++; if (bus.if_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", i, bus.if_valid); else n_pass++;
            n_total++; if (bus.imem_req !== 1'b0) $display("FAIL stall_req[%0d]: got %b want 0", i, bus.imem_req); else n_pass++;
            n_total++; if (bus.instr !== e.ins) $display("FAIL stall_instr[%0d]: got %h want %h", i, bus.instr, e.ins); else n_pass++;
            n_total++; if (bus.pc_out !== e.pc) $display("FAIL stall_pc_out[%0d]: got %h want %h", i, bus.pc_out, e.pc); else n_pass++;
            n_total++; if (bus.imem_addr !== 8'h01) $display("FAIL stall_addr[%0d]: got %h want 01", i, bus.imem_addr); else n_pass++;
        end
`ifdef IF_PERF_COUNT_EN
        n_total++; if (stall_count !== 16'd5) $display("FAIL stall_count: got %0d want 5", stall_count); else n_pass++;
        n_total++; if (fetch_count !== 16'd1) $display("FAIL fetch_count: got %0d want 1", fetch_count); else n_pass++;
`endif
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        n_total++; if (bus.if_valid !== 1'b0) $display("FAIL stall_release: got %b want 0", bus.if_valid); else n_pass++;
    endtask

    task automatic test_imem_wait();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            n_total++; if (bus.imem_req !== 1'b1) $display("FAIL wait_req[%0d]: got %b want 1", i, bus.imem_req); else n_pass++;
            n_total++; if (bus.imem_addr !== m_pc) $display("FAIL wait_addr[%0d]: got %h want %h", i, bus.imem_addr, m_pc); else n_pass++;
            n_total++; if (bus.if_valid !== 1'b0) $display("FAIL wait_valid[%0d]: got %b want 0", i, bus.if_valid); else n_pass++;
        end
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        e = sb.pop_front();
        n_total++; if (bus.if_valid !== 1'b1) $display("FAIL wait_done_valid: got %b want 1", bus.if_valid); else n_pass++;
        n_total++; if (bus.instr !== e.ins) $display("FAIL wait_done_instr: got %h want %h", bus.instr, e.ins); else n_pass++;
        n_total++; if (bus.pc_out !== e.pc) $display("FAIL wait_done_pc_out: got %h want %h", bus.pc_out, e.pc); else n_pass++;
        drive(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_jump();
        exp_t e;
        logic [15:0] held;
        drive(1'b1, 1'b1, 1'b1, 8'h40);
        n_total++; if (bus.if_valid !== 1'b0) $display("FAIL jump_drop_valid: got %b want 0", bus.if_valid); else n_pass++;
        n_total++; if (bus.imem_addr !== 8'h40) $display("FAIL jump_addr: got %h want 40", bus.imem_addr); else n_pass++;
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        e = sb.pop_front();
        n_total++; if (bus.pc_out !== 8'h40) $display("FAIL jump_pc_out: got %h want 40", bus.pc_out); else n_pass++;
        n_total++; if (bus.instr !== e.ins) $display("FAIL jump_instr: got %h want %h", bus.instr, e.ins); else n_pass++;
        held = e.ins;
        // Jump while holding, with decode also ready: instruction consumed, fetch restarts at target.
        drive(1'b0, 1'b1, 1'b1, 8'h10);
        n_total++; if (bus.if_valid !== 1'b0) $display("FAIL jump_full_valid: got %b want 0", bus.if_valid); else n_pass++;
        n_total++; if (bus.imem_addr !== 8'h10) $display("FAIL jump_full_addr: got %h want 10", bus.imem_addr); else n_pass++;
        n_total++; if (bus.instr !== held) $display("FAIL jump_full_instr_hold: got %h want %h", bus.instr, held); else n_pass++;
    endtask

    task automatic test_wrap();
        exp_t e;
        drive(1'b0, 1'b1, 1'b1, 8'hFF);
        n_total++; if (bus.imem_addr !== 8'hFF) $display("FAIL wrap_pre_addr: got %h want ff", bus.imem_addr); else n_pass++;
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        e = sb.pop_front();
        n_total++; if (bus.pc_out !== 8'hFF) $display("FAIL wrap_pc_out: got %h want ff", bus.pc_out); else n_pass++;
        n_total++; if (bus.instr !== e.ins) $display("FAIL wrap_instr: got %h want %h", bus.instr, e.ins); else n_pass++;
        n_total++; if (bus.imem_addr !== 8'h00) $display("FAIL wrap_addr: got %h want 00", bus.imem_addr); else n_pass++;
        drive(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_reset_mid_stall();
        exp_t e;
        drive(1'b0, 1'b1, 1'b1, 8'h20);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        n_total++; if (bus.if_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b want 1", bus.if_valid); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++; if (bus.if_valid !== 1'b0) $display("FAIL async_reset_valid: got %b want 0", bus.if_valid); else n_pass++;
        n_total++; if (bus.instr !== 16'h0000) $display("FAIL async_reset_instr: got %h want 0000", bus.instr); else n_pass++;
        n_total++; if (bus.imem_req !== 1'b0) $display("FAIL async_reset_req: got %b want 0", bus.imem_req); else n_pass++;
        n_total++; if (bus.imem_addr !== 8'h00) $display("FAIL async_reset_addr: got %h want 00", bus.imem_addr); else n_pass++;
        // A pending response during reset must be ignored.
        bus.imem_ready = 1'b1;
        @(negedge clk);
        n_total++; if (bus.if_valid !== 1'b0) $display("FAIL reset_ignore_valid: got %b want 0", bus.if_valid); else n_pass++;
        reset = 1'b0;
        m_pc = 8'h00; m_full = 1'b0; sb.delete();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        e = sb.pop_front();
        n_total++; if (bus.pc_out !== 8'h00) $display("FAIL resume_pc_out: got %h want 00", bus.pc_out); else n_pass++;
        n_total++; if (bus.instr !== 16'h2000) $display("FAIL resume_instr: got %h want 2000", bus.instr); else n_pass++;
        n_total++; if (bus.imem_addr !== 8'h01) $display("FAIL resume_addr: got %h want 01", bus.imem_addr); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_pc    = 8'h00;
        m_full  = 1'b0;
        m_new   = 1'b0;
        reset   = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'(i * 16'h1357) ^ 16'hA5C3;
        end
        mem[0] = 16'h2000;
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_imem_wait();
        test_jump();
        test_wrap();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
